coax_tx_sequencer: RTL and testbench

- Programmable word sequencer that drives the coax transmitter's load/data interface.
- Holds a small pattern memory of up to DEPTH words. Issues those words to the transmitter as one frame, then waits a programmable inter-frame gap.
- Runs continuously or one frame per start pulse.
- Sits between top-level control (host registers or test logic) and coax_tx. Replaces a fixed word reloaded by a free-running counter.

---
 rtl/coax_tx_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_coax_tx_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_tx_sequencer.sv
// ---------------------------------------------------------------------------
// coax_tx_sequencer
//
// Programmable word sequencer in front of coax_tx. A small pattern memory
// holds up to DEPTH words; a frame issues the first len_s of them to the
// transmitter through a one-cycle load strobe, waits for the line to go
// quiet, pulses frame_done and then idles for a programmable gap before the
// next frame may start. Frames run back to back (mode=0) or one per start
// pulse (mode=1).
//
// Ports:
//   clk        system clock (19 MHz coax domain)
//   reset      synchronous, active-high reset
//   enable     permits new frames to start
//   mode       0 = continuous, 1 = single-shot
//   start      single-cycle frame request (mode=1 only)
//   length     words per frame, 0..DEPTH (larger values clamp to DEPTH)
//   gap        idle cycles between frames
//   wr_en      pattern memory write strobe
//   wr_addr    pattern memory write address
//   wr_data    pattern memory write data
//   tx_ready   transmitter can accept a word this cycle
//   tx_active  transmitter is driving the line
//   load       one-cycle word strobe to coax_tx
//   data       word presented with load, held until the next load
//   busy       high whenever the sequencer is not idle
//   frame_done one-cycle pulse when a frame has fully left the line
// ---------------------------------------------------------------------------
module coax_tx_sequencer #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tx_ready,
  input  logic                  tx_active,
  output logic                  load,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    DRAIN,
    GAP
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE   = GAP_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic [ADDR_WIDTH:0]   len_s, len_s_nxt;
  logic [GAP_WIDTH-1:0]  gap_s, gap_s_nxt;
  logic [GAP_WIDTH-1:0]  gap_cnt, gap_cnt_nxt;
  logic                  load_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  busy_nxt;
  logic                  frame_done_nxt;

  logic                  trigger;
  logic                  last_word;

  // Pattern memory is deliberately outside the reset domain so a reset does
  // not wipe a programmed pattern. A read in the same cycle as a write to the
  // same address sees the old word because both happen on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign trigger   = enable && (!mode || start);
  // len_s is at least 1 whenever this is used, so len_s-1 never wraps.
  assign last_word = ({1'b0, idx} == (len_s - LEN_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      len_s      <= '0;
      gap_s      <= '0;
      gap_cnt    <= '0;
      load       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      len_s      <= len_s_nxt;
      gap_s      <= gap_s_nxt;
      gap_cnt    <= gap_cnt_nxt;
      load       <= load_nxt;
      data       <= data_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    len_s_nxt      = len_s;
    gap_s_nxt      = gap_s;
    gap_cnt_nxt    = gap_cnt;
    load_nxt       = 1'b0;
    data_nxt       = data;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        // A zero-length request is dropped silently: no frame, no done pulse.
        if (trigger && (length != '0)) begin
          len_s_nxt = (length > DEPTH_LEN) ? DEPTH_LEN : length;
          gap_s_nxt = gap;
          idx_nxt   = '0;
          state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        if (tx_ready) begin
          load_nxt  = 1'b1;
          data_nxt  = mem[idx];
          state_nxt = HOLD;
        end
      end

      // tx_ready is ignored here so coax_tx has a cycle to drop it after
      // seeing load; otherwise a stale ready could issue a second word.
      HOLD: begin
        if (last_word) begin
          state_nxt = DRAIN;
        end else begin
          idx_nxt   = idx + IDX_ONE;
          state_nxt = ISSUE;
        end
      end

      DRAIN: begin
        if (!tx_active && tx_ready) begin
          frame_done_nxt = 1'b1;
          if (gap_s == '0) begin
            state_nxt = IDLE;
          end else begin
            gap_cnt_nxt = gap_s;
            state_nxt   = GAP;
          end
        end
      end

      // Leaving on the cycle the counter reads 1 makes GAP last exactly
      // gap_s cycles; the <= guard keeps the counter from ever underflowing.
      GAP: begin
        if (gap_cnt <= GAP_ONE) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_coax_tx_sequencer
//
// Scoreboard bench for coax_tx_sequencer. Stimulus pushes the expected word
// indices and end-of-frame marker of each requested frame; a negedge monitor
// pops them as load / frame_done appear and compares against a behavioural
// copy of the pattern memory. Frame timing is checked against the frame
// budget: first load 2 cycles after start, words 2 cycles apart (or paced by
// the transmitter), done 2*n+2 cycles after start, and GAP of gap cycles.
// ---------------------------------------------------------------------------
module tb_coax_tx_sequencer;

  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int GW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic          start;
  logic [AW:0]   length;
  logic [GW-1:0] gap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          tx_ready;
  logic          tx_active;
  logic          load;
  logic [DW-1:0] data;
  logic          busy;
  logic          frame_done;

  coax_tx_sequencer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .GAP_WIDTH (GW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .start     (start),
    .length    (length),
    .gap       (gap),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .tx_ready  (tx_ready),
    .tx_active (tx_active),
    .load      (load),
    .data      (data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #26 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural pattern memory: follows every write, unaffected by reset.
  logic [DW-1:0] model_mem [DEPTH];
  always @(posedge clk) begin
    if (wr_en) model_mem[wr_addr] <= wr_data;
  end

  typedef struct {
    bit is_done;
    int idx;
  } exp_t;

  exp_t          exp_q[$];
  int            load_cyc_q[$];
  int            done_cyc_q[$];
  logic [DW-1:0] load_dat_q[$];
  int            load_count    = 0;
  int            busy_fall_cyc = -1;
  logic          prev_ready    = 1'b0;
  logic          prev_active   = 1'b0;
  logic          prev_busy     = 1'b0;
  exp_t          mon_e;

  // Transmitter model: 0 = always ready and quiet, 1 = busy after each load
  // (ready low 7 cycles, active 40 cycles), 2 = stalled (never ready).
  int tx_mode = 0;
  int rdy_cnt = 0;
  int act_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame(input int len);
    int n;
    exp_t e;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.idx     = i;
      exp_q.push_back(e);
    end
    if (n > 0) begin
      e.is_done = 1'b1;
      e.idx     = 0;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: pops one expectation per load or frame_done.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_count++;
      load_cyc_q.push_back(cyc);
      load_dat_q.push_back(data);
      checkOutput("load_needs_ready", 32'(prev_ready), 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_load: data=%0h at cycle %0d, nothing pending", data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("load_order", 32'(mon_e.is_done), 32'd0);
        if (!mon_e.is_done)
          checkOutput($sformatf("word%0d", mon_e.idx), 32'(data),
                      32'(model_mem[mon_e.idx[AW-1:0]]));
      end
    end
    if (frame_done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      checkOutput("done_needs_quiet_line", 32'(prev_active), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_frame_done: at cycle %0d, nothing pending", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("done_order", 32'(mon_e.is_done), 32'd1);
      end
    end
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_ready  = tx_ready;
    prev_active = tx_active;
    prev_busy   = busy;
  end

  initial begin
    tx_ready  = 1'b1;
    tx_active = 1'b0;
    forever begin
      tick();
      case (tx_mode)
        0: begin
          rdy_cnt   = 0;
          act_cnt   = 0;
          tx_ready  = 1'b1;
          tx_active = 1'b0;
        end
        1: begin
          if (load === 1'b1) begin
            rdy_cnt = 7;
            act_cnt = 40;
          end else begin
            if (rdy_cnt > 0) rdy_cnt--;
            if (act_cnt > 0) act_cnt--;
          end
          tx_ready  = (rdy_cnt == 0);
          tx_active = (act_cnt > 0);
        end
        default: begin
          tx_ready  = 1'b0;
          tx_active = 1'b0;
        end
      endcase
    end
  end

  task automatic write_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d[DW-1:0];
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) write_word(a, int'($urandom_range(0, 1023)));
  endtask

  // Single-shot frame request; pushes the expected frame and returns the
  // cycle in which start was high.
  task automatic applyStimulus(input int len, input int gp, output int s);
    mode   = 1'b1;
    enable = 1'b1;
    length = len[AW:0];
    gap    = gp[GW-1:0];
    s      = cyc;
    push_frame(len);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic clear_obs();
    load_cyc_q.delete();
    done_cyc_q.delete();
    load_dat_q.delete();
    busy_fall_cyc = -1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(busy === 1'b0 && exp_q.size() == 0)) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles", name, busy, exp_q.size(), budget);
    end
    tick();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_frame_timing(input string name, input int s, input int len, input int gp);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    checkOutput({name, "_loads"}, 32'(load_cyc_q.size()), 32'(n));
    if (n == 0) begin
      checkOutput({name, "_no_done"}, 32'(done_cyc_q.size()), 32'd0);
    end else begin
      if (load_cyc_q.size() == n) begin
        checkOutput({name, "_first_load"}, 32'(load_cyc_q[0] - s), 32'd2);
        for (int i = 1; i < n; i++)
          checkOutput({name, "_spacing"}, 32'(load_cyc_q[i] - load_cyc_q[i-1]), 32'd2);
      end
      checkOutput({name, "_dones"}, 32'(done_cyc_q.size()), 32'd1);
      if (done_cyc_q.size() >= 1) begin
        checkOutput({name, "_done_latency"}, 32'(done_cyc_q[0] - s), 32'(2 * n + 2));
        checkOutput({name, "_gap_cycles"}, 32'(busy_fall_cyc - done_cyc_q[0]), 32'(gp));
      end
    end
  endtask

  initial begin
    #(52 * 120000);
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int e;
    int lc0;
    int rl;
    int rg;

    reset   = 1'b1;
    enable  = 1'b0;
    mode    = 1'b1;
    start   = 1'b0;
    length  = '0;
    gap     = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) tick();
    checkOutput("reset_load", 32'(load), 32'd0);
    checkOutput("reset_data", 32'(data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    tick();

    // Basic single-shot frame of three known words.
    for (int a = 3; a < DEPTH; a++) write_word(a, int'($urandom_range(0, 1023)));
    write_word(0, 'h005);
    write_word(1, 'h3FF);
    write_word(2, 'h155);
    clear_obs();
    applyStimulus(3, 0, s);
    wait_idle(100, "basic");
    check_frame_timing("basic", s, 3, 0);
    if (load_dat_q.size() == 3) begin
      checkOutput("basic_word0", 32'(load_dat_q[0]), 32'h005);
      checkOutput("basic_word1", 32'(load_dat_q[1]), 32'h3FF);
      checkOutput("basic_word2", 32'(load_dat_q[2]), 32'h155);
    end

    // Pattern survives a reset.
    reset_dut();
    clear_obs();
    applyStimulus(3, 0, s);
    wait_idle(100, "retain");
    check_frame_timing("retain", s, 3, 0);

    // Continuous mode: frames every 2*2+1+10+1 = 16 cycles; enable dropped
    // during the third frame lets that frame and its gap finish.
    clear_obs();
    lc0    = load_count;
    mode   = 1'b0;
    length = 4'd2;
    gap    = 16'd10;
    for (int k = 0; k < 3; k++) push_frame(2);
    enable = 1'b1;
    e      = cyc;
    while (cyc < e + 34) tick();
    enable = 1'b0;
    wait_idle(200, "continuous");
    repeat (40) tick();
    checkOutput("cont_dones", 32'(done_cyc_q.size()), 32'd3);
    if (done_cyc_q.size() == 3) begin
      checkOutput("cont_first_done", 32'(done_cyc_q[0] - e), 32'd6);
      checkOutput("cont_period_a", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd16);
      checkOutput("cont_period_b", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd16);
      checkOutput("cont_last_gap", 32'(busy_fall_cyc - done_cyc_q[2]), 32'd10);
    end
    checkOutput("cont_total_loads", 32'(load_count - lc0), 32'd6);

    // Backpressure: words paced by tx_ready, done only after tx_active falls.
    tx_mode = 1;
    tick();
    clear_obs();
    applyStimulus(3, 2, s);
    wait_idle(500, "backpressure");
    tx_mode = 0;
    tick();
    checkOutput("bp_loads", 32'(load_cyc_q.size()), 32'd3);
    checkOutput("bp_dones", 32'(done_cyc_q.size()), 32'd1);
    if (load_cyc_q.size() == 3 && done_cyc_q.size() == 1) begin
      checkOutput("bp_first_load", 32'(load_cyc_q[0] - s), 32'd2);
      checkOutput("bp_spacing_a", 32'(load_cyc_q[1] - load_cyc_q[0]), 32'd8);
      checkOutput("bp_spacing_b", 32'(load_cyc_q[2] - load_cyc_q[1]), 32'd8);
      checkOutput("bp_done_after_active", 32'(done_cyc_q[0] - load_cyc_q[2]), 32'd41);
      checkOutput("bp_gap_cycles", 32'(busy_fall_cyc - done_cyc_q[0]), 32'd2);
    end

    // Hazards: start and a write to addr 1 both land while word 0 is held.
    clear_obs();
    applyStimulus(3, 0, s);
    tick();
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 10'h2AA;
    tick();
    start   = 1'b0;
    wr_en   = 1'b0;
    wait_idle(100, "hazard");
    repeat (20) tick();
    check_frame_timing("hazard", s, 3, 0);
    if (load_dat_q.size() >= 2) checkOutput("hazard_word1", 32'(load_dat_q[1]), 32'h2AA);

    // length = 0 does nothing.
    clear_obs();
    applyStimulus(0, 0, s);
    repeat (20) tick();
    check_frame_timing("len0", s, 0, 0);
    checkOutput("len0_busy", 32'(busy), 32'd0);

    // length = 15 clamps to 8 words.
    fill_random();
    clear_obs();
    applyStimulus(15, 1, s);
    wait_idle(100, "len15");
    check_frame_timing("len15", s, 15, 1);

    // Randomised single-shot frames.
    for (int it = 0; it < 6; it++) begin
      fill_random();
      rl = int'($urandom_range(0, 15));
      rg = int'($urandom_range(0, 6));
      clear_obs();
      applyStimulus(rl, rg, s);
      wait_idle(200, "random");
      repeat (3) tick();
      check_frame_timing($sformatf("rand%0d", it), s, rl, rg);
    end

    // Reset while waiting in ISSUE aborts the frame at once.
    tx_mode = 2;
    repeat (2) tick();
    clear_obs();
    applyStimulus(4, 0, s);
    tick();
    checkOutput("issue_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    checkOutput("abort_load", 32'(load), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    reset   = 1'b0;
    tx_mode = 0;
    repeat (10) tick();
    checkOutput("abort_no_loads", 32'(load_cyc_q.size()), 32'd0);
    checkOutput("abort_idle", 32'(busy), 32'd0);

    // Longest gap.
    clear_obs();
    applyStimulus(1, 'hFFFF, s);
    wait_idle(70000, "maxgap");
    check_frame_timing("maxgap", s, 1, 65535);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
